refill_dados: RTL and testbench

REFILL_DADOS -- requirements
Module: refill_dados

---
 rtl/refill_pkg.sv | 21 ++
 rtl/refill_dados.sv | 141 ++++++++++++++
 tb/tb_refill_dados.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/refill_pkg.sv
// -----------------------------------------------------------------------------
// refill_pkg
// Shared definitions for the data-cache refill engine (refill_dados):
//   - refill_state_e : refill FSM state encoding
//   - INDEX_W, TAG_W, LINE_W, WORD_W : cache geometry constants
// -----------------------------------------------------------------------------
package refill_pkg;

    localparam int unsigned INDEX_W = 3;
    localparam int unsigned TAG_W   = 26;
    localparam int unsigned LINE_W  = 64;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FILL  = 2'd3
    } refill_state_e;

endpackage

// File: rtl/refill_dados.sv
// -----------------------------------------------------------------------------
// refill_dados
// Data-cache line refill engine. On a miss it latches the line address,
// fetches the two 32-bit words of the 8-byte line from memory (one beat per
// word, each beat held until mem_ack) and then writes the assembled line into
// the cache with a single-cycle fill_we strobe.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   miss        in   cache miss request (cache stall output)
//   miss_addr   in   byte address of the missing load
//   mem_req     out  memory read request, held until accepted
//   mem_addr    out  word-aligned memory read address
//   mem_ack     in   memory beat accept, mem_rdata valid same cycle
//   mem_rdata   in   memory read data
//   fill_we     out  one-cycle cache line write strobe
//   fill_index  out  line index  (latched addr[5:3])
//   fill_tag    out  line tag    (latched addr[31:6])
//   fill_data   out  line data, word0 in [31:0], word1 in [63:32]
//   busy        out  high whenever the engine is not idle
//
// Configuration macro:
//   REFILL_CRITICAL_WORD_FIRST_EN - when defined, the first beat fetches the
//   word addressed by the miss (addr[2]); otherwise word0 is always first.
//
// All outputs are registered; they are computed from the next state inside
// the single FSM process.
// -----------------------------------------------------------------------------
module refill_dados
    import refill_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                miss,
    input  logic [31:0]         miss_addr,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    input  logic                mem_ack,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic                fill_we,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [TAG_W-1:0]    fill_tag,
    output logic [LINE_W-1:0]   fill_data,
    output logic                busy
);

    refill_state_e state;

    // Word slot fetched by the first beat; the second beat fetches the other.
    logic crit_word;

`ifndef REFILL_CRITICAL_WORD_FIRST_EN
    assign crit_word = 1'b0;
`endif

    // Byte offset bits never take part in line addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_addr[2:0];

    // A beat completes only while the request is actually presented.
    logic beat_done;
    assign beat_done = mem_req & mem_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_we    <= 1'b0;
            fill_index <= '0;
            fill_tag   <= '0;
            fill_data  <= '0;
            busy       <= 1'b0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
            crit_word  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    fill_we <= 1'b0;
                    if (miss) begin
                        // The tag/index registers double as the latched line
                        // address, so later miss_addr changes cannot leak in.
                        fill_tag   <= miss_addr[31:6];
                        fill_index <= miss_addr[5:3];
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
                        crit_word  <= miss_addr[2];
                        mem_addr   <= {miss_addr[31:3], miss_addr[2], 2'b00};
`else
                        mem_addr   <= {miss_addr[31:3], 3'b000};
`endif
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= BEAT0;
                    end
                end

                BEAT0: begin
                    if (beat_done) begin
                        if (crit_word)
                            fill_data[LINE_W-1:WORD_W] <= mem_rdata;
                        else
                            fill_data[WORD_W-1:0] <= mem_rdata;
                        // Only the word-select bit changes: no carry into the tag.
                        mem_addr <= {fill_tag, fill_index, ~crit_word, 2'b00};
                        state    <= BEAT1;
                    end
                end

                BEAT1: begin
                    if (beat_done) begin
                        if (crit_word)
                            fill_data[WORD_W-1:0] <= mem_rdata;
                        else
                            fill_data[LINE_W-1:WORD_W] <= mem_rdata;
                        mem_req <= 1'b0;
                        fill_we <= 1'b1;
                        state   <= FILL;
                    end
                end

                FILL: begin
                    // miss is still the old request here; it is re-evaluated
                    // in IDLE on the following edge.
                    fill_we <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    mem_req <= 1'b0;
                    fill_we <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refill_dados.sv
// -----------------------------------------------------------------------------
// tb_refill_dados
// Self-checking bench for refill_dados. Expected lines are pushed to a
// scoreboard when a miss is issued and popped when fill_we is observed.
// -----------------------------------------------------------------------------
module tb_refill_dados;
    import refill_pkg::*;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic                clock;
    logic                reset;
    logic                miss;
    logic [31:0]         miss_addr;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_ack;
    logic [WORD_W-1:0]   mem_rdata;
    logic                fill_we;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic [LINE_W-1:0]   fill_data;
    logic                busy;

    typedef struct {
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [LINE_W-1:0]  data;
    } line_t;

    line_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    refill_dados dut (
        .clock      (clock),
        .reset      (reset),
        .miss       (miss),
        .miss_addr  (miss_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] addr, input logic [31:0] data, input int wt);
        for (int k = 0; k < wt; k++) begin
            check({tag, "_req_wait"},  {63'd0, mem_req}, 64'd1);
            check({tag, "_addr_wait"}, {32'd0, mem_addr}, {32'd0, addr});
            check({tag, "_we_wait"},   {63'd0, fill_we}, 64'd0);
            step();
        end
        check({tag, "_req"},  {63'd0, mem_req}, 64'd1);
        check({tag, "_addr"}, {32'd0, mem_addr}, {32'd0, addr});
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
    endtask

    // One complete refill. d0/d1 are the data returned by the first/second beat.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                              input int wt, input bit hold, input logic [31:0] next_addr);
        line_t e;
        line_t got;
        logic  fs;
        logic [31:0] a0;
        logic [31:0] a1;
        fs = CWF ? addr[2] : 1'b0;
        a0 = {addr[31:3], fs, 2'b00};
        a1 = {addr[31:3], ~fs, 2'b00};
        e.index = addr[5:3];
        e.tag   = addr[31:6];
        e.data  = fs ? {d0, d1} : {d1, d0};
        sb.push_back(e);

        miss      = 1'b1;
        miss_addr = addr;
        step();
        if (!hold) miss = 1'b0;
        miss_addr = ~addr;           // must not disturb the latched line
        beat("beat0", a0, d0, wt);
        beat("beat1", a1, d1, wt);

        check("fill_we", {63'd0, fill_we}, 64'd1);
        check("fill_req_low", {63'd0, mem_req}, 64'd0);
        if (sb.size() == 0) begin
            check("sb_empty_on_fill", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            check("fill_index", {61'd0, fill_index}, {61'd0, got.index});
            check("fill_tag",   {38'd0, fill_tag},   {38'd0, got.tag});
            check("fill_data",  fill_data,           got.data);
        end
        if (hold) miss_addr = next_addr;
        step();
        check("post_fill_we",   {63'd0, fill_we}, 64'd0);
        check("post_fill_busy", {63'd0, busy},    64'd0);
        check("post_fill_req",  {63'd0, mem_req}, 64'd0);
    endtask

    task automatic idle_checks(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check({tag, "_we"},   {63'd0, fill_we}, 64'd0);
            check({tag, "_busy"}, {63'd0, busy},    64'd0);
            check({tag, "_req"},  {63'd0, mem_req}, 64'd0);
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        miss      = 1'b0;
        miss_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        check("rst_req",   {63'd0, mem_req}, 64'd0);
        check("rst_addr",  {32'd0, mem_addr}, 64'd0);
        check("rst_we",    {63'd0, fill_we}, 64'd0);
        check("rst_index", {61'd0, fill_index}, 64'd0);
        check("rst_tag",   {38'd0, fill_tag}, 64'd0);
        check("rst_data",  fill_data, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        reset = 1'b0;
        step();
        idle_checks("idle", 2);

        // Basic zero-wait refill: fill_we lands in the third cycle.
        run_refill(32'h0000_0048, 32'h1111_1111, 32'h2222_2222, 0, 1'b0, '0);

        // Four wait states per beat: fill lands in cycle 11.
        run_refill(32'h0000_12F0, 32'hA5A5_0001, 32'h5A5A_0002, 4, 1'b0, '0);

        // Miss on word1 of the line (critical-word-first ordering when enabled).
        run_refill(32'h0000_0104, 32'hCAFE_0104, 32'hBEEF_0100, 0, 1'b0, '0);

        // Top of the address space: no carry out of the line.
        run_refill(32'hFFFF_FFFC, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1, 1'b0, '0);

        // Reset during BEAT1.
        miss      = 1'b1;
        miss_addr = 32'h0000_0080;
        step();
        miss = 1'b0;
        check("rb_beat0_req", {63'd0, mem_req}, 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        check("rb_beat1_addr", {32'd0, mem_addr}, 64'h84);
        reset = 1'b1;
        #1;
        check("rb_req",  {63'd0, mem_req}, 64'd0);
        check("rb_busy", {63'd0, busy},    64'd0);
        check("rb_we",   {63'd0, fill_we}, 64'd0);
        check("rb_data", fill_data,        64'd0);
        step();
        reset   = 1'b0;
        mem_ack = 1'b1;               // stray ack after reset
        step();
        idle_checks("rb_after", 3);
        mem_ack = 1'b0;

        // Back-to-back: miss held through FILL, new address after fill_we.
        run_refill(32'h0000_0048, 32'h3333_3333, 32'h4444_4444, 0, 1'b1, 32'h0000_0200);
        run_refill(32'h0000_0200, 32'h5555_5555, 32'h6666_6666, 0, 1'b0, '0);

        // Spurious ack in IDLE.
        mem_ack = 1'b1;
        idle_checks("spur", 3);
        mem_ack = 1'b0;

        check("sb_drained", {32'd0, sb.size()}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
